// File: rtl/vx_warp_state_model.sv
// rtl/vx_warp_state_model.sv - predictive per-warp scheduler state (active, stall, tmask, PC, barriers)
// Events apply in the order wspawn, tmc, br, barrier, stall-set; every output is registered.
module vx_warp_state_model #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_THREADS  = 4,
  parameter int PC_BITS      = 30,
  parameter int NUM_BARRIERS = 4,
  parameter logic [PC_BITS-1:0] STARTUP_PC = '0,
  parameter int NW_WIDTH = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int NB_WIDTH = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wspawn_valid,
  input  logic [NUM_WARPS-1:0]             wspawn_mask,
  input  logic [PC_BITS-1:0]               wspawn_pc,
  input  logic                             tmc_valid,
  input  logic [NW_WIDTH-1:0]              tmc_wid,
  input  logic [NUM_THREADS-1:0]           tmc_mask,
  input  logic                             br_valid,
  input  logic [NW_WIDTH-1:0]              br_wid,
  input  logic                             br_taken,
  input  logic [PC_BITS-1:0]               br_pc,
  input  logic                             stall_valid,
  input  logic [NW_WIDTH-1:0]              stall_wid,
  input  logic                             bar_valid,
  input  logic [NW_WIDTH-1:0]              bar_wid,
  input  logic [NB_WIDTH-1:0]              bar_id,
  input  logic [NW_WIDTH:0]                bar_count,
  output logic [NUM_WARPS-1:0]             active_warps,
  output logic [NUM_WARPS-1:0]             stalled_warps,
  output logic [NUM_WARPS*NUM_THREADS-1:0] thread_masks,
  output logic [NUM_WARPS*PC_BITS-1:0]     warp_pcs,
  output logic                             bar_release,
  output logic [NB_WIDTH-1:0]              bar_release_id,
  output logic                             err_inactive,
  output logic                             err_spawn_active
);

  logic [NUM_WARPS-1:0]                         active_q, active_d;
  logic [NUM_WARPS-1:0]                         stalled_q, stalled_d;
  logic [NUM_WARPS-1:0][NUM_THREADS-1:0]        tmask_q, tmask_d;
  logic [NUM_WARPS-1:0][PC_BITS-1:0]            pc_q, pc_d;
  logic [NUM_BARRIERS-1:0][NUM_WARPS-1:0]       member_q, member_d;
  logic                                         rel_q, rel_d;
  logic [NB_WIDTH-1:0]                          rel_id_q, rel_id_d;
  logic                                         err_in_q, err_in_d;
  logic                                         err_sp_q, err_sp_d;

  logic [NUM_WARPS-1:0] spawned_active;
  logic [NUM_WARPS-1:0] bar_members;
  logic [NW_WIDTH:0]    bar_pop;
  logic                 tmc_ok, br_ok, bar_ok, stall_ok;

  // Compare against each legal ID so an out-of-range wid never indexes the mask.
  function automatic logic is_live(input logic [NW_WIDTH-1:0] wid,
                                   input logic [NUM_WARPS-1:0] act);
    is_live = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (wid == NW_WIDTH'(w) && act[w]) is_live = 1'b1;
    end
  endfunction

  always_comb begin
    active_d    = active_q;
    stalled_d   = stalled_q;
    tmask_d     = tmask_q;
    pc_d        = pc_q;
    member_d    = member_q;
    rel_d       = 1'b0;
    rel_id_d    = '0;
    err_in_d    = 1'b0;
    err_sp_d    = 1'b0;
    bar_members = '0;
    bar_pop     = '0;

    if (wspawn_valid) begin
      for (int w = 1; w < NUM_WARPS; w++) begin
        if (wspawn_mask[w]) begin
          if (active_q[w]) begin
            err_sp_d = 1'b1;
          end else begin
            active_d[w] = 1'b1;
            pc_d[w]     = wspawn_pc;
            tmask_d[w]  = NUM_THREADS'(1);
          end
        end
      end
    end

    // Legality is judged after wspawn but before tmc can deactivate the warp.
    spawned_active = active_d;
    tmc_ok   = tmc_valid   && is_live(tmc_wid,   spawned_active);
    br_ok    = br_valid    && is_live(br_wid,    spawned_active);
    bar_ok   = bar_valid   && is_live(bar_wid,   spawned_active);
    stall_ok = stall_valid && is_live(stall_wid, spawned_active);
    err_in_d = (tmc_valid && !tmc_ok) || (br_valid && !br_ok) ||
               (bar_valid && !bar_ok) || (stall_valid && !stall_ok);

    if (tmc_ok) begin
      tmask_d[tmc_wid]   = tmc_mask;
      stalled_d[tmc_wid] = 1'b0;
      if (tmc_mask == '0) active_d[tmc_wid] = 1'b0;
    end

    if (br_ok) begin
      stalled_d[br_wid] = 1'b0;
      if (br_taken) pc_d[br_wid] = br_pc;
    end

    if (bar_ok) begin
      bar_members        = member_q[bar_id] | (NUM_WARPS'(1) << bar_wid);
      stalled_d[bar_wid] = 1'b1;
      for (int w = 0; w < NUM_WARPS; w++) begin
        bar_pop = bar_pop + {{NW_WIDTH{1'b0}}, bar_members[w]};
      end
      if (bar_pop >= bar_count) begin
        stalled_d        = stalled_d & ~bar_members;
        member_d[bar_id] = '0;
        rel_d            = 1'b1;
        rel_id_d         = bar_id;
      end else begin
        member_d[bar_id] = bar_members;
      end
    end

    if (stall_ok) stalled_d[stall_wid] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q    <= NUM_WARPS'(1);
      stalled_q   <= '0;
      tmask_q     <= '0;
      tmask_q[0]  <= NUM_THREADS'(1);
      pc_q        <= {NUM_WARPS{STARTUP_PC}};
      member_q    <= '0;
      rel_q       <= 1'b0;
      rel_id_q    <= '0;
      err_in_q    <= 1'b0;
      err_sp_q    <= 1'b0;
    end else begin
      active_q    <= active_d;
      stalled_q   <= stalled_d;
      tmask_q     <= tmask_d;
      pc_q        <= pc_d;
      member_q    <= member_d;
      rel_q       <= rel_d;
      rel_id_q    <= rel_id_d;
      err_in_q    <= err_in_d;
      err_sp_q    <= err_sp_d;
    end
  end

  assign active_warps     = active_q;
  assign stalled_warps    = stalled_q;
  assign thread_masks     = tmask_q;
  assign warp_pcs         = pc_q;
  assign bar_release      = rel_q;
  assign bar_release_id   = rel_id_q;
  assign err_inactive     = err_in_q;
  assign err_spawn_active = err_sp_q;

endmodule
